ins_stream: RTL and testbench
=============================

# ins_stream

Parametrised instruction sequencer that replaces hand-poked `Ins` stimulus in front of the IF/ID join datapath. It holds a small program of up to DEPTH instruction words and issues them, one per accepted cycle, to the decode stage. It honours a downstream stall, can run once or loop, and counts issued instructions. It sits between a bench or loader and the `Ins` input of the join datapath, and can also serve as a boot ROM front end.

## Interface
- WIDTH, 32, instruction word width
- DEPTH, 16, program store depth in words (power of two)
- ADDR_W, 4, log2(DEPTH)
- CNT_W, 16, width of the issue counter

- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- ld_en  in  1  write `ld_data` to the program store at `ld_addr`
- ld_addr  in  ADDR_W  program store write address
- ld_data  in  WIDTH  program store write data
- start  in  1  begin issuing from address 0
- stop  in  1  abort issuing and return to IDLE
- loop_en  in  1  wrap to address 0 after `last_addr` instead of finishing
- last_addr  in  ADDR_W  address of the final instruction of the program
- stall  in  1  downstream not accepting; hold the current instruction
- Ins  out  WIDTH  current instruction; all-zero (NOP) when not valid
- ins_valid  out  1  `Ins` holds a program word
- busy  out  1  state is RUN
- done  out  1  state is DONE
- cur_addr  out  ADDR_W  store address of the word on `Ins`
- issue_cnt  out  CNT_W  number of accepted issues since last start; saturating

## Operation
- States are IDLE, RUN and DONE. RST forces IDLE.
- Program store is a DEPTH x WIDTH register array with no reset. Contents survive RST.
- `ld_en` is honoured only in IDLE or DONE; it is ignored in RUN.
- A load and a start in the same cycle: the write lands, but the word issued at address 0 is the pre-write value if `ld_addr` is 0. Loaders must not rely on same-cycle bypass.
- IDLE:
  - `Ins`=0, `ins_valid`=0.
  - On `start`: next state RUN, `Ins`=mem[0], `cur_addr`=0, `ins_valid`=1, `issue_cnt`=0.
- RUN:
  - An accept is `ins_valid & ~stall`.
  - On an accept with `cur_addr` != `last_addr`: `cur_addr`+1 and `Ins`=mem[`cur_addr`+1].
  - On an accept with `cur_addr` == `last_addr` and `loop_en`=1: `cur_addr`=0 and `Ins`=mem[0].
  - On an accept with `cur_addr` == `last_addr` and `loop_en`=0: next state DONE, `Ins`=0, `ins_valid`=0.
  - Each accept increments `issue_cnt`. The counter saturates at 2^CNT_W-1.
  - `stall`=1 holds `Ins`, `cur_addr` and `issue_cnt` unchanged.
- DONE:
  - `done`=1, `Ins`=0, `ins_valid`=0.
  - `issue_cnt` and `cur_addr` hold their final values.
  - `start` restarts exactly as from IDLE.
- `stop` in any state: next state IDLE, `Ins`=0, `ins_valid`=0, `cur_addr`=0. `issue_cnt` holds.
- `stop` and `start` in the same cycle: `stop` wins.
- `start` while in RUN is ignored.
- `loop_en` and `last_addr` are sampled every cycle. A change mid-run takes effect at the next comparison.
- `last_addr` = 0 gives a single-instruction program; with `loop_en`=1 it repeats mem[0].

## Timing
- Reset values:
  - `Ins`=0, `ins_valid`=0, `busy`=0, `done`=0
  - `cur_addr`=0, `issue_cnt`=0, state IDLE
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Start latency is 1 cycle: `start` sampled at edge N gives `Ins`=mem[0] valid after edge N.
- Throughput is 1 word/cycle with `stall`=0. A program of L=`last_addr`+1 words with no stall and `loop_en`=0:
  - `ins_valid` is high for exactly L cycles.
  - `done` rises on the edge after the L-th accept.
- `stall` is sampled at the same edge as the accept decision; it has zero-cycle effect on advance.
- RST asserted mid-RUN: IDLE on that edge, outputs at reset values, store contents retained.

## Test plan
- Load mem[0]=0x21490010 (ADDI $t1,$t2,16), mem[1]=0x014B4820 (ADD $t1,$t2,$t3); `last_addr`=1, `loop_en`=0, pulse `start` -> `Ins` shows 0x21490010 then 0x014B4820 on consecutive cycles, then `Ins`=0 with `done`=1 and `issue_cnt`=2.
- Same program, `stall`=1 for 3 cycles while `cur_addr`=0 -> `Ins` holds 0x21490010 for 4 cycles, `issue_cnt` stays 0 during the stall, final `issue_cnt`=2.
- `loop_en`=1, `last_addr`=1, run 7 cycles without stall -> `cur_addr` sequence 0,1,0,1,0,1,0, `issue_cnt`=7, `done` never asserts.
- RST asserted during RUN at `cur_addr`=1, then `start` -> all outputs at reset values for one cycle, then mem[0] reissued with original contents intact.
- `ld_en` with `ld_addr`=0 and `ld_data`=0xFFFFFFFF while in RUN -> store unchanged, and after restart `Ins`=0x21490010.
- `start` and `stop` in the same cycle from IDLE -> stays IDLE with `ins_valid`=0; `last_addr`=0 and `loop_en`=0 -> exactly one valid cycle, then DONE.

Source files
------------

// File: rtl/ins_stream.sv
// Instruction sequencer: issues a small loaded program word-by-word to decode,
// honouring downstream stall, with run-once or loop modes and an issue counter.
module ins_stream #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WIDTH-1:0]  ld_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              stall,
    output logic [WIDTH-1:0]  Ins,
    output logic              ins_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [CNT_W-1:0]  issue_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   mem_r [DEPTH];
    logic [WIDTH-1:0]   ins_r, ins_s;
    logic               valid_r, valid_s;
    logic [ADDR_W-1:0]  addr_r, addr_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               accept_s;
    logic [ADDR_W-1:0]  next_addr_s;

    // Program store write port; no reset so contents survive RST.
    always_ff @(posedge CLK) begin
        if (ld_en && (state_r != ST_RUN)) begin
            mem_r[ld_addr] <= ld_data;
        end
    end

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_s     = state_r;
        ins_s       = ins_r;
        valid_s     = valid_r;
        addr_s      = addr_r;
        cnt_s       = cnt_r;
        accept_s    = valid_r & ~stall;
        next_addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};

        if (stop) begin
            state_s = ST_IDLE;
            ins_s   = {WIDTH{1'b0}};
            valid_s = 1'b0;
            addr_s  = {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        // Reads the registered store, so a same-cycle load is not bypassed.
                        state_s = ST_RUN;
                        ins_s   = mem_r[0];
                        valid_s = 1'b1;
                        addr_s  = {ADDR_W{1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        if (cnt_r != {CNT_W{1'b1}}) begin
                            cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            cnt_s = cnt_r;
                        end
                        if (addr_r != last_addr) begin
                            addr_s = next_addr_s;
                            ins_s  = mem_r[next_addr_s];
                        end else if (loop_en) begin
                            addr_s = {ADDR_W{1'b0}};
                            ins_s  = mem_r[0];
                        end else begin
                            state_s = ST_DONE;
                            ins_s   = {WIDTH{1'b0}};
                            valid_s = 1'b0;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    ins_s   = {WIDTH{1'b0}};
                    valid_s = 1'b0;
                    addr_s  = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            ins_r   <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            ins_r   <= ins_s;
            valid_r <= valid_s;
            addr_r  <= addr_s;
            cnt_r   <= cnt_s;
        end
    end

    assign Ins       = ins_r;
    assign ins_valid = valid_r;
    assign busy      = (state_r == ST_RUN);
    assign done      = (state_r == ST_DONE);
    assign cur_addr  = addr_r;
    assign issue_cnt = cnt_r;

endmodule

// File: tb/tb_ins_stream.sv
// Directed bench for ins_stream: expected issued words are queued at start
// and compared against Ins as each word is accepted.
module tb_ins_stream;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;
    localparam logic [31:0] W_A = 32'h2149_0010;
    localparam logic [31:0] W_B = 32'h014B_4820;
    localparam logic [31:0] W_C = 32'hDEAD_BEEF;

    logic              CLK = 1'b0;
    logic              RST, ld_en, start, stop, loop_en, stall;
    logic [ADDR_W-1:0] ld_addr, last_addr;
    logic [WIDTH-1:0]  ld_data;
    logic [WIDTH-1:0]  Ins;
    logic              ins_valid, busy, done;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  issue_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    ins_stream #(.WIDTH(WIDTH), .DEPTH(16), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .stop(stop), .loop_en(loop_en), .last_addr(last_addr),
        .stall(stall), .Ins(Ins), .ins_valid(ins_valid), .busy(busy), .done(done),
        .cur_addr(cur_addr), .issue_cnt(issue_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Call after setting stall for the coming edge: compares Ins to the
    // scoreboard head, popping it only when the word will be accepted.
    task automatic observe(input string tag);
        if (ins_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_unexpected"}, {32'd0, Ins}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk(tag, {32'd0, Ins}, {32'd0, exp_q[0]});
                if (stall == 1'b0) void'(exp_q.pop_front());
            end
        end else begin
            chk({tag, "_nop"}, {32'd0, Ins}, 64'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ins"}, {32'd0, Ins}, 64'd0);
        chk({tag, "_valid"}, {63'd0, ins_valid}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_addr"}, {60'd0, cur_addr}, 64'd0);
        chk({tag, "_cnt"}, {48'd0, issue_cnt}, 64'd0);
    endtask

    task automatic launch(input logic [31:0] w0, input logic [31:0] w1, input int n);
        exp_q.push_back(w0);
        if (n > 1) exp_q.push_back(w1);
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        RST = 1'b1; ld_en = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        stall = 1'b0; ld_addr = 4'd0; last_addr = 4'd1; ld_data = 32'd0;
        @(negedge CLK);
        cycle();
        check_reset_outputs("reset");
        RST = 1'b0;

        ld_en = 1'b1; ld_addr = 4'd0; ld_data = W_A; cycle();
        ld_addr = 4'd1; ld_data = W_B; cycle();
        ld_en = 1'b0;

        // Basic two-word run
        launch(W_A, W_B, 2);
        chk("run_busy", {63'd0, busy}, 64'd1);
        chk("run_addr0", {60'd0, cur_addr}, 64'd0);
        observe("run_w0"); cycle();
        chk("run_addr1", {60'd0, cur_addr}, 64'd1);
        observe("run_w1"); cycle();
        observe("run_end");
        chk("run_done", {63'd0, done}, 64'd1);
        chk("run_cnt", {48'd0, issue_cnt}, 64'd2);
        chk("run_q", exp_q.size(), 64'd0);

        // Stall on first word
        launch(W_A, W_B, 2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            observe("stall_hold");
            chk("stall_cnt", {48'd0, issue_cnt}, 64'd0);
            chk("stall_addr", {60'd0, cur_addr}, 64'd0);
            cycle();
        end
        stall = 1'b0;
        observe("stall_w0"); cycle();
        observe("stall_w1"); cycle();
        chk("stall_done", {63'd0, done}, 64'd1);
        chk("stall_cnt_final", {48'd0, issue_cnt}, 64'd2);

        // Loop mode, 7 accepts
        loop_en = 1'b1;
        launch(W_A, W_B, 0);
        exp_q.delete();
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back((k % 2 == 0) ? W_A : W_B);
            chk("loop_addr", {60'd0, cur_addr}, 64'(k % 2));
            chk("loop_done", {63'd0, done}, 64'd0);
            observe("loop_w");
            cycle();
        end
        chk("loop_cnt", {48'd0, issue_cnt}, 64'd7);
        chk("loop_addr_now", {60'd0, cur_addr}, 64'd1);

        // Reset mid-run, then restart with store intact
        RST = 1'b1; cycle(); RST = 1'b0;
        exp_q.delete();
        check_reset_outputs("midrst");
        loop_en = 1'b0;
        launch(W_A, W_B, 2);
        observe("rst_w0"); cycle();
        observe("rst_w1"); cycle();
        chk("rst_done", {63'd0, done}, 64'd1);

        // Load ignored while running
        launch(W_A, W_B, 2);
        ld_en = 1'b1; ld_addr = 4'd0; ld_data = 32'hFFFF_FFFF;
        observe("ldrun_w0"); cycle();
        ld_en = 1'b0;
        observe("ldrun_w1"); cycle();
        launch(W_A, W_B, 2);
        observe("ldrun_re_w0"); cycle();
        observe("ldrun_re_w1"); cycle();
        chk("ldrun_done", {63'd0, done}, 64'd1);

        // Stop from DONE, then simultaneous start+stop
        stop = 1'b1; cycle();
        chk("stop_done", {63'd0, done}, 64'd0);
        chk("stop_busy", {63'd0, busy}, 64'd0);
        chk("stop_cnt_hold", {48'd0, issue_cnt}, 64'd2);
        start = 1'b1; cycle();
        start = 1'b0; stop = 1'b0;
        chk("startstop_valid", {63'd0, ins_valid}, 64'd0);
        chk("startstop_busy", {63'd0, busy}, 64'd0);

        // Single-instruction program
        last_addr = 4'd0;
        launch(W_A, W_B, 1);
        observe("single_w0"); cycle();
        chk("single_valid", {63'd0, ins_valid}, 64'd0);
        chk("single_done", {63'd0, done}, 64'd1);
        chk("single_cnt", {48'd0, issue_cnt}, 64'd1);

        // Load and start together: pre-write word issued, new word next time
        ld_en = 1'b1; ld_addr = 4'd0; ld_data = W_C;
        launch(W_A, W_B, 1);
        ld_en = 1'b0;
        observe("bypass_old"); cycle();
        launch(W_C, W_B, 1);
        observe("bypass_new"); cycle();
        chk("bypass_done", {63'd0, done}, 64'd1);
        chk("final_q", exp_q.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
